// File: rtl/oc8051_gm_pkg.sv
// Shared types and constants for the oc8051 golden-model front end.
// Holds the length encodings and the fetch-queue entry layout.
package oc8051_gm_pkg;

    localparam logic [7:0] OC8051_OP_A5_ILLEGAL = 8'hA5;

    localparam logic [1:0] LEN1 = 2'd1;
    localparam logic [1:0] LEN2 = 2'd2;
    localparam logic [1:0] LEN3 = 2'd3;

    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  op0;
        logic [7:0]  op1;
        logic [7:0]  op2;
        logic [1:0]  len;
        logic        illegal;
    } fetch_entry_t;

endpackage

// File: rtl/oc8051_gm_oplen.sv
// MCS-51 opcode length table, purely combinational.
// Shared between the fetch stage and the golden-model decoder.
module oc8051_gm_oplen
    import oc8051_gm_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len,
    output logic       illegal
);

    always_comb begin
        len = LEN1;
        casez (opcode)
            // three-byte forms: long jumps/calls, bit branches, dir/#imm pairs, CJNE, DJNZ dir
            8'h02, 8'h12, 8'h10, 8'h20, 8'h30,
            8'h43, 8'h53, 8'h63, 8'h75, 8'h85, 8'h90,
            8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'b1011_1???,
            8'hD5:
                len = LEN3;
            // AJMP/ACALL in every row
            8'h?1:
                len = LEN2;
            8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35,
            8'h40, 8'h42, 8'h44, 8'h45,
            8'h50, 8'h52, 8'h54, 8'h55,
            8'h60, 8'h62, 8'h64, 8'h65,
            8'h70, 8'h72, 8'h74, 8'h76, 8'h77, 8'b0111_1???,
            8'h80, 8'h82, 8'h86, 8'h87, 8'b1000_1???,
            8'h92, 8'h94, 8'h95,
            8'hA0, 8'hA2, 8'hA6, 8'hA7, 8'b1010_1???,
            8'hB0, 8'hB2,
            8'hC0, 8'hC2, 8'hC5,
            8'hD0, 8'hD2, 8'b1101_1???,
            8'hE5, 8'hF5:
                len = LEN2;
            default:
                len = LEN1;
        endcase
    end

    assign illegal = (opcode == OC8051_OP_A5_ILLEGAL);

endmodule

// File: rtl/oc8051_gm_fetch.sv
// Golden-model fetch stage: reads three ROM bytes at PC, decodes length,
// queues whole instructions and hands them to execute over valid/ready.
module oc8051_gm_fetch
    import oc8051_gm_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] rd_addr_0,
    output logic [15:0] rd_addr_1,
    output logic [15:0] rd_addr_2,
    input  logic [7:0]  rd_data_0,
    input  logic [7:0]  rd_data_1,
    input  logic [7:0]  rd_data_2,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [15:0] insn_pc,
    output logic [7:0]  insn_op0,
    output logic [7:0]  insn_op1,
    output logic [7:0]  insn_op2,
    output logic [1:0]  insn_len,
    output logic        insn_illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [15:0]   pc;
    fetch_entry_t  queue [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [1:0]    dec_len;
    logic          dec_illegal;
    fetch_entry_t  new_entry;
    fetch_entry_t  head;
    logic          enq;
    logic          deq;

    assign rd_addr_0 = pc;
    assign rd_addr_1 = pc + 16'd1;
    assign rd_addr_2 = pc + 16'd2;

    oc8051_gm_oplen u_oplen (
        .opcode  (rd_data_0),
        .len     (dec_len),
        .illegal (dec_illegal)
    );

    // Bytes beyond the instruction length are zeroed so the entry is canonical.
    always_comb begin
        new_entry         = '0;
        new_entry.pc      = pc;
        new_entry.op0     = rd_data_0;
        new_entry.op1     = (dec_len != LEN1) ? rd_data_1 : 8'h00;
        new_entry.op2     = (dec_len == LEN3) ? rd_data_2 : 8'h00;
        new_entry.len     = dec_len;
        new_entry.illegal = dec_illegal;
    end

    assign insn_valid = (count != '0);
    assign deq        = insn_valid && insn_ready;
    // A full queue can still accept when the head leaves in the same cycle.
    assign enq        = !redirect_valid && ((count < DEPTH_C) || deq);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                queue[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc     <= redirect_pc;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (enq) begin
                queue[wr_ptr] <= new_entry;
                wr_ptr        <= wr_ptr + AW'(1);
                pc            <= pc + {14'd0, dec_len};
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    assign head         = queue[rd_ptr];
    assign insn_pc      = head.pc;
    assign insn_op0     = head.op0;
    assign insn_op1     = head.op1;
    assign insn_op2     = head.op2;
    assign insn_len     = head.len;
    assign insn_illegal = head.illegal;

endmodule

// File: tb/tb_oc8051_gm_fetch.sv
// Directed bench for oc8051_gm_fetch with a behavioural 64 KiB code ROM.
module tb_oc8051_gm_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] rd_addr_0, rd_addr_1, rd_addr_2;
    logic [7:0]  rd_data_0, rd_data_1, rd_data_2;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        insn_valid;
    logic        insn_ready;
    logic [15:0] insn_pc;
    logic [7:0]  insn_op0, insn_op1, insn_op2;
    logic [1:0]  insn_len;
    logic        insn_illegal;

    logic [7:0]  rom [0:65535];

    int vectors;
    int miscompares;

    assign rd_data_0 = rom[rd_addr_0];
    assign rd_data_1 = rom[rd_addr_1];
    assign rd_data_2 = rom[rd_addr_2];

    oc8051_gm_fetch #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_addr_0      (rd_addr_0),
        .rd_addr_1      (rd_addr_1),
        .rd_addr_2      (rd_addr_2),
        .rd_data_0      (rd_data_0),
        .rd_data_1      (rd_data_1),
        .rd_data_2      (rd_data_2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .insn_valid     (insn_valid),
        .insn_ready     (insn_ready),
        .insn_pc        (insn_pc),
        .insn_op0       (insn_op0),
        .insn_op1       (insn_op1),
        .insn_op2       (insn_op2),
        .insn_len       (insn_len),
        .insn_illegal   (insn_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_rom();
        for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
    endtask

    // Reset held across two negedges, released away from the active edge.
    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_rom();
        insn_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (insn_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", insn_valid); end
        vectors++; if (insn_pc !== 16'h0000) begin miscompares++; $display("FAIL rst_pc: got %h want 0000", insn_pc); end
        vectors++; if ({insn_op0, insn_op1, insn_op2} !== 24'h000000) begin miscompares++; $display("FAIL rst_ops: got %h want 000000", {insn_op0, insn_op1, insn_op2}); end
        vectors++; if ({insn_len, insn_illegal} !== 3'b000) begin miscompares++; $display("FAIL rst_len_ill: got %b want 000", {insn_len, insn_illegal}); end
        vectors++; if ({rd_addr_0, rd_addr_1, rd_addr_2} !== 48'h0000_0001_0002) begin miscompares++; $display("FAIL rst_addr: got %h want 000000010002", {rd_addr_0, rd_addr_1, rd_addr_2}); end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (insn_valid !== 1'b1) begin miscompares++; $display("FAIL nop_valid[%0d]: got %b want 1", i, insn_valid); end
            vectors++; if (insn_pc !== 16'(i)) begin miscompares++; $display("FAIL nop_pc[%0d]: got %h want %h", i, insn_pc, 16'(i)); end
            vectors++; if (insn_len !== 2'd1) begin miscompares++; $display("FAIL nop_len[%0d]: got %0d want 1", i, insn_len); end
        end
    endtask

    task automatic test_lengths();
        clear_rom();
        rom[0] = 8'h90; rom[1] = 8'h12; rom[2] = 8'h34;
        rom[3] = 8'h74; rom[4] = 8'h55; rom[5] = 8'h00;
        rom[6] = 8'hEE; rom[7] = 8'hDD;
        insn_ready = 1'b1;
        do_reset();
        @(negedge clk);
        vectors++; if ({insn_pc, insn_op0, insn_op1, insn_op2} !== 40'h0000_90_12_34) begin miscompares++; $display("FAIL len3_head: got %h want 0000901234", {insn_pc, insn_op0, insn_op1, insn_op2}); end
        vectors++; if ({insn_len, insn_illegal} !== 3'b110) begin miscompares++; $display("FAIL len3_len: got %b want 110", {insn_len, insn_illegal}); end
        @(negedge clk);
        vectors++; if ({insn_pc, insn_op0, insn_op1, insn_op2} !== 40'h0003_74_55_00) begin miscompares++; $display("FAIL len2_head: got %h want 0003745500", {insn_pc, insn_op0, insn_op1, insn_op2}); end
        vectors++; if (insn_len !== 2'd2) begin miscompares++; $display("FAIL len2_len: got %0d want 2", insn_len); end
        @(negedge clk);
        vectors++; if ({insn_pc, insn_op0, insn_op1, insn_op2} !== 40'h0005_00_00_00) begin miscompares++; $display("FAIL len1_head: got %h want 0005000000", {insn_pc, insn_op0, insn_op1, insn_op2}); end
        vectors++; if (insn_len !== 2'd1) begin miscompares++; $display("FAIL len1_len: got %0d want 1", insn_len); end
    endtask

    task automatic test_backpressure();
        clear_rom();
        rom[0] = 8'h02; rom[1] = 8'h00; rom[2] = 8'h10;
        rom[3] = 8'h02; rom[4] = 8'h00; rom[5] = 8'h20;
        insn_ready = 1'b0;
        do_reset();
        @(negedge clk);
        vectors++; if (rd_addr_0 !== 16'h0003) begin miscompares++; $display("FAIL bp_addr1: got %h want 0003", rd_addr_0); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            vectors++; if ({insn_valid, insn_pc, insn_op0, insn_op1, insn_op2, insn_len} !== {1'b1, 16'h0000, 8'h02, 8'h00, 8'h10, 2'd3}) begin
                miscompares++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h op=%h%h%h len=%0d want v=1 pc=0000 op=020010 len=3", i, insn_valid, insn_pc, insn_op0, insn_op1, insn_op2, insn_len);
            end
            vectors++; if (rd_addr_0 !== 16'h0006) begin miscompares++; $display("FAIL bp_addr_stall[%0d]: got %h want 0006", i, rd_addr_0); end
            if (i < 3) @(negedge clk);
        end
        insn_ready = 1'b1;
        @(negedge clk);
        vectors++; if ({insn_pc, insn_op0, insn_op1, insn_op2} !== 40'h0003_02_00_20) begin miscompares++; $display("FAIL bp_drain1: got %h want 0003020020", {insn_pc, insn_op0, insn_op1, insn_op2}); end
        vectors++; if (rd_addr_0 !== 16'h0007) begin miscompares++; $display("FAIL bp_full_enq: got %h want 0007", rd_addr_0); end
        @(negedge clk);
        vectors++; if ({insn_valid, insn_pc, insn_len} !== {1'b1, 16'h0006, 2'd1}) begin miscompares++; $display("FAIL bp_drain2: got v=%b pc=%h len=%0d want v=1 pc=0006 len=1", insn_valid, insn_pc, insn_len); end
    endtask

    task automatic test_redirect();
        clear_rom();
        rom[16'h0030] = 8'h75; rom[16'h0031] = 8'h12; rom[16'h0032] = 8'h34;
        insn_ready = 1'b0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0030;
        insn_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        vectors++; if (insn_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush: got %b want 0", insn_valid); end
        vectors++; if (rd_addr_0 !== 16'h0030) begin miscompares++; $display("FAIL redir_addr: got %h want 0030", rd_addr_0); end
        @(negedge clk);
        vectors++; if ({insn_valid, insn_pc, insn_op0, insn_op1, insn_op2, insn_len} !== {1'b1, 16'h0030, 8'h75, 8'h12, 8'h34, 2'd3}) begin
            miscompares++; $display("FAIL redir_target: got v=%b pc=%h op=%h%h%h len=%0d want v=1 pc=0030 op=751234 len=3", insn_valid, insn_pc, insn_op0, insn_op1, insn_op2, insn_len);
        end
    endtask

    task automatic test_wrap();
        rom[16'hFFFE] = 8'h02; rom[16'hFFFF] = 8'hAB; rom[16'h0000] = 8'hCD;
        insn_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        vectors++; if ({rd_addr_0, rd_addr_1, rd_addr_2} !== 48'hFFFE_FFFF_0000) begin miscompares++; $display("FAIL wrap_addr: got %h want FFFEFFFF0000", {rd_addr_0, rd_addr_1, rd_addr_2}); end
        @(negedge clk);
        vectors++; if ({insn_pc, insn_op0, insn_op1, insn_op2} !== 40'hFFFE_02_AB_CD) begin miscompares++; $display("FAIL wrap_head: got %h want FFFE02ABCD", {insn_pc, insn_op0, insn_op1, insn_op2}); end
        vectors++; if (rd_addr_0 !== 16'h0001) begin miscompares++; $display("FAIL wrap_next_pc: got %h want 0001", rd_addr_0); end
    endtask

    task automatic test_illegal_async_reset();
        rom[16'h0040] = 8'hA5; rom[16'h0041] = 8'h77; rom[16'h0042] = 8'h88;
        insn_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        vectors++; if ({insn_pc, insn_op0, insn_op1, insn_op2} !== 40'h0040_A5_00_00) begin miscompares++; $display("FAIL ill_head: got %h want 0040A50000", {insn_pc, insn_op0, insn_op1, insn_op2}); end
        vectors++; if ({insn_len, insn_illegal} !== 3'b011) begin miscompares++; $display("FAIL ill_flag: got %b want 011", {insn_len, insn_illegal}); end
        vectors++; if (rd_addr_0 !== 16'h0041) begin miscompares++; $display("FAIL ill_next_pc: got %h want 0041", rd_addr_0); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (insn_valid !== 1'b0) begin miscompares++; $display("FAIL async_rst_valid: got %b want 0", insn_valid); end
        vectors++; if (rd_addr_0 !== 16'h0000) begin miscompares++; $display("FAIL async_rst_pc: got %h want 0000", rd_addr_0); end
        vectors++; if ({insn_pc, insn_illegal} !== 17'h0) begin miscompares++; $display("FAIL async_rst_head: got %h want 00000", {insn_pc, insn_illegal}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        insn_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        test_reset();
        test_lengths();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_illegal_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/oc8051_gm_fetch.md
Name: oc8051_gm_fetch

Overview:
- Golden-model instruction fetch stage that sits directly downstream of the golden-model symbolic code ROM.
- Drives the ROM's three combinational byte-read ports (rd_addr_0..2) with PC, PC+1 and PC+2.
- Decodes the instruction length from the opcode byte and buffers whole instructions in a small queue.
- Presents the queued instructions to the golden-model execute stage over a valid/ready handshake and accepts PC redirects for jumps, calls and interrupts.

Parameters:
- DEPTH, 2, number of instruction entries in the fetch queue (power of two, at least 2).
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr_0  out  16  code ROM byte address = fetch PC.
- rd_addr_1  out  16  fetch PC+1 (mod 2^16).
- rd_addr_2  out  16  fetch PC+2 (mod 2^16).
- rd_data_0  in  8  ROM byte at rd_addr_0, combinational, same cycle.
- rd_data_1  in  8  ROM byte at rd_addr_1.
- rd_data_2  in  8  ROM byte at rd_addr_2.
- redirect_valid  in  1  load a new fetch PC and flush the queue.
- redirect_pc  in  16  target PC.
- insn_valid  out  1  head queue entry is valid.
- insn_ready  in  1  consumer accepts the head entry this cycle.
- insn_pc  out  16  PC of the head instruction.
- insn_op0  out  8  opcode byte.
- insn_op1  out  8  second byte, zero if len < 2.
- insn_op2  out  8  third byte, zero if len < 3.
- insn_len  out  2  length in bytes: 1, 2 or 3.
- insn_illegal  out  1  head opcode is 8'hA5 (reserved).

Behaviour:
- Reset is asynchronous and applies immediately:
  - fetch PC = RESET_PC; queue count = 0; read/write pointers = 0.
  - insn_valid = 0, insn_pc = 0, insn_op0/1/2 = 0, insn_len = 0, insn_illegal = 0.
- rd_addr_* are combinational from the fetch PC. rd_addr_1 and rd_addr_2 wrap modulo 2^16 (PC=FFFF gives 0000 and 0001).
- Length decode follows the MCS-51 instruction-set length table:
  - len 3: 02, 12, 90, 43, 53, 63, 75, 85, B4-BF, D5, and 10/20/30 (bit branches).
  - len 2: all AJMP/ACALL opcodes (x1), 40/50/60/70/80, 24/34/44/54/64/74 etc. per table, and all direct-address and #imm forms.
  - len 1: everything else, including A5.
  - Implemented as a pure case table.
- Enqueue condition: !redirect_valid && (count < DEPTH || deq).
  - deq = insn_valid && insn_ready.
  - A full queue with a simultaneous dequeue still enqueues.
- On enqueue at posedge:
  - Entry gets {PC, rd_data_0, masked rd_data_1, masked rd_data_2, len, illegal}.
  - Fetch PC <= PC + len (mod 2^16).
- On dequeue: read pointer advances. Count is updated by +enq −deq.
- Outputs come from the head entry, registered queue storage, no comb path from rd_data_*.
  - insn_valid = (count != 0).
  - When count = 0, insn_* fields hold their last values and are don't-care.
- Latency:
  - After reset release, the first insn_valid=1 appears 1 cycle after the first clk edge.
  - Steady-state throughput is 1 instruction/cycle with insn_ready held high.
- Redirect has priority over everything:
  - At posedge with redirect_valid=1: queue flushed (count = 0, pointers = 0), fetch PC <= redirect_pc.
  - Any dequeue in that cycle still counts as accepted by the consumer, but no enqueue occurs.
  - Next cycle: insn_valid=0 and rd_addr_0 = redirect_pc. The following cycle delivers the target instruction.
- Handshake: when insn_valid=1 and insn_ready=0, all insn_* outputs are stable until accepted or flushed.
- Reset mid-operation discards the queue and any pending redirect.

Decomposition:
- Shared package oc8051_gm_pkg:
  - OC8051_OP_A5_ILLEGAL constant.
  - Length encoding constants LEN1/LEN2/LEN3.
  - Queue entry struct type: pc, op0, op1, op2, len, illegal.
- One sub-module, oc8051_gm_oplen: purely combinational opcode to {len, illegal} table, reused later by the golden-model decoder.

Test Plan:
- Reset with ROM bytes 00 00 00, insn_ready=1 → cycle 1: insn_valid=1, insn_pc=0000, len=1; next insn_pc=0001, 0002 each cycle.
- ROM 90 12 34 74 55 00 → successive heads:
  - pc=0000, op=90/12/34, len=3.
  - pc=0003, op=74/55/00, len=2.
  - pc=0005, len=1.
- insn_ready=0 for 5 cycles with opcodes 02 00 10 → queue fills to DEPTH; outputs held at pc=0000, op=02/00/10; rd_addr_0 stops advancing at 0006 (two 3-byte entries); release → in-order drain.
- redirect_valid=1, redirect_pc=0x0030 while queue full and insn_ready=1 → next cycle insn_valid=0, rd_addr_0=0030; following cycle insn_pc=0030.
- Wrap case: redirect_pc=FFFE, opcode 02 → rd_addr_1=FFFF, rd_addr_2=0000; next PC=0001.
- Opcode A5 → insn_illegal=1, len=1, op1=op2=00; async rst asserted mid-cycle → insn_valid drops immediately, PC=RESET_PC.
